// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets N_REQ character sources share one UART TX
// buffer write port. The owner keeps the port until its message ends, its
// burst allowance runs out, or it sits idle for TIMEOUT cycles.
module uart_tx_arb #(
    parameter int unsigned N_REQ           = 4,
    parameter int unsigned UART_DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned TIMEOUT         = 64,
    localparam int unsigned ID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_last,
    input  logic [N_REQ*UART_DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]                 req_ready,
    output logic                             tx_wr,
    output logic [UART_DATA_WIDTH-1:0]       tx_d_in,
    input  logic                             tx_full,
    output logic [ID_W-1:0]                  grant_id,
    output logic                             busy
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
    // Idle counter only needs to reach TIMEOUT-1.
    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic                g_valid;
    logic                g_last;
    logic [UART_DATA_WIDTH-1:0] g_data;
    logic                transfer;
    logic [BEAT_W-1:0]   beat_inc;
    logic [ID_W-1:0]     grant_next_ptr;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        logic [ID_W-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Select the granted requester's valid/last/data.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*UART_DATA_WIDTH +: UART_DATA_WIDTH];
            end
        end
    end

    // Write-port handshake and status outputs, all derived from current state.
    always_comb begin
        busy     = (state_q == ST_STREAM);
        transfer = busy && g_valid && !tx_full;
        tx_wr    = transfer;
        tx_d_in  = g_data;
        grant_id = grant_q;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready[i] = transfer && (grant_q == ID_W'(i));
        end
    end

    // Next-state, grant, pointer and counter updates.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        idle_d   = idle_q;

        beat_inc       = beat_q + 1'b1;
        grant_next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    idle_d  = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (transfer) begin
                    // A transfer always completes first; release is then
                    // decided by message end or exhausted burst allowance.
                    beat_d = beat_inc;
                    idle_d = '0;
                    if (g_last || (beat_inc == BEAT_W'(MAX_BURST))) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next_ptr;
                    end
                end else if (!g_valid) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next_ptr;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                // Valid but tx_full: hold everything, never release.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with default parameters (4 requesters,
// 8-bit chars, burst 16, timeout 64). Inputs change on the falling edge and
// outputs are checked 1ns later.
module tb_uart_tx_arb;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_wr;
    logic [7:0]  tx_d_in;
    logic        tx_full;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp;
    int n_err;

    uart_tx_arb #(
        .N_REQ(4),
        .UART_DATA_WIDTH(8),
        .MAX_BURST(16),
        .TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_wr(tx_wr),
        .tx_d_in(tx_d_in),
        .tx_full(tx_full),
        .grant_id(grant_id),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    // Called 1ns-before-check at the first idle cycle: expects 64 idle cycles
    // still owned, then release.
    task automatic timeout_check(input logic [1:0] exp_grant);
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            chk("to_busy", busy, 1);
            chk("to_wr", tx_wr, 0);
        end
        chk("to_grant", grant_id, exp_grant);
        @(negedge clock);
        #1;
        chk("to_release", busy, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_full   = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_wr", tx_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        @(negedge clock);
        reset = 1'b1;

        // Requester 2: three characters, last on the third
        @(negedge clock);
        req_valid = 4'b0100;
        set_data(2, 8'hA0);
        #1;
        chk("a_arb_busy", busy, 0);
        chk("a_arb_wr", tx_wr, 0);
        chk("a_arb_ready", req_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            set_data(2, 8'(8'hA0 + k));
            req_last[2] = (k == 2);
            #1;
            chk("a_busy", busy, 1);
            chk("a_grant", grant_id, 2);
            chk("a_wr", tx_wr, 1);
            chk("a_ready", req_ready, 4'b0100);
            chk("a_data", tx_d_in, 8'hA0 + k);
        end
        @(negedge clock);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("a_done_busy", busy, 0);
        chk("a_done_wr", tx_wr, 0);

        // Requesters 0 and 3 together; pointer is at 3
        @(negedge clock);
        req_valid = 4'b1001;
        set_data(0, 8'h10);
        set_data(3, 8'h30);
        #1;
        chk("b_arb_busy", busy, 0);
        @(negedge clock);
        #1;
        chk("b_grant3", grant_id, 3);
        chk("b_ready3", req_ready, 4'b1000);
        chk("b_data30", tx_d_in, 8'h30);
        @(negedge clock);
        set_data(3, 8'h31);
        req_last[3] = 1'b1;
        set_data(0, 8'h1F);
        #1;
        chk("b_grant3_2", grant_id, 3);
        chk("b_data31", tx_d_in, 8'h31);
        chk("b_ready3_2", req_ready, 4'b1000);
        @(negedge clock);
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        #1;
        chk("b_mid_busy", busy, 0);
        chk("b_mid_wr", tx_wr, 0);
        @(negedge clock);
        #1;
        chk("b_grant0", grant_id, 0);
        chk("b_ready0", req_ready, 4'b0001);
        chk("b_data1f", tx_d_in, 8'h1F);
        chk("b_wr0", tx_wr, 1);
        @(negedge clock);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("b_done_busy", busy, 0);

        // Requester 1: 20 characters with no last; burst limit is 16
        @(negedge clock);
        req_valid = 4'b0010;
        set_data(1, 8'h40);
        #1;
        chk("c_arb_busy", busy, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            set_data(1, 8'(8'h40 + k));
            #1;
            chk("c_wr", tx_wr, 1);
            chk("c_grant", grant_id, 1);
            chk("c_data", tx_d_in, 8'h40 + k);
        end
        @(negedge clock);
        set_data(1, 8'h50);
        #1;
        chk("c_burst_rel_busy", busy, 0);
        chk("c_burst_rel_wr", tx_wr, 0);
        for (int k = 16; k < 20; k++) begin
            @(negedge clock);
            set_data(1, 8'(8'h40 + k));
            #1;
            chk("c2_wr", tx_wr, 1);
            chk("c2_grant", grant_id, 1);
            chk("c2_data", tx_d_in, 8'h40 + k);
        end
        @(negedge clock);
        req_valid = '0;
        timeout_check(2'd1);

        // Requester 0 (pointer at 2): one char, then idle until timeout
        @(negedge clock);
        req_valid = 4'b0001;
        set_data(0, 8'h60);
        #1;
        chk("d_arb_busy", busy, 0);
        @(negedge clock);
        #1;
        chk("d_grant0", grant_id, 0);
        chk("d_wr", tx_wr, 1);
        chk("d_data", tx_d_in, 8'h60);
        @(negedge clock);
        req_valid = '0;
        timeout_check(2'd0);

        // Long tx_full stall with valid high: no release, no write
        @(negedge clock);
        req_valid = 4'b0001;
        set_data(0, 8'h70);
        tx_full = 1'b1;
        #1;
        chk("f_arb_busy", busy, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #1;
            chk("f_busy", busy, 1);
            chk("f_wr", tx_wr, 0);
            chk("f_ready", req_ready, 0);
            chk("f_data", tx_d_in, 8'h70);
        end
        @(negedge clock);
        tx_full  = 1'b0;
        req_last = 4'b0001;
        #1;
        chk("f_wr_after", tx_wr, 1);
        chk("f_data_after", tx_d_in, 8'h70);
        chk("f_grant", grant_id, 0);
        @(negedge clock);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("f_done_busy", busy, 0);

        // Requester 3 (pointer at 1): reset during the 5th of 10 chars
        @(negedge clock);
        req_valid = 4'b1000;
        set_data(3, 8'h80);
        #1;
        chk("e_arb_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            set_data(3, 8'(8'h80 + k));
            #1;
            chk("e_wr", tx_wr, 1);
            chk("e_grant", grant_id, 3);
            chk("e_data", tx_d_in, 8'h80 + k);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("e_rst_wr", tx_wr, 0);
        chk("e_rst_busy", busy, 0);
        chk("e_rst_grant", grant_id, 0);
        chk("e_rst_ready", req_ready, 0);
        @(negedge clock);
        #1;
        chk("e_rst_hold_wr", tx_wr, 0);
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 4'b1001;
        set_data(0, 8'h90);
        req_last  = 4'b0001;
        #1;
        chk("e_post_busy", busy, 0);
        @(negedge clock);
        #1;
        chk("e_post_grant", grant_id, 0);
        chk("e_post_wr", tx_wr, 1);
        chk("e_post_data", tx_d_in, 8'h90);
        @(negedge clock);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("e_end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the UART TX buffer write port.
REQ-002 SHALL have parameter UART_DATA_WIDTH, default 8, character width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum characters per grant.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum idle cycles tolerated while granted.
REQ-005 SHALL have port clock, input, 1, single clock for all logic.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, N_REQ, per-requester character valid.
REQ-008 SHALL have port req_last, input, N_REQ, per-requester last character of message.
REQ-009 SHALL have port req_data, input, N_REQ*UART_DATA_WIDTH, per-requester character; requester i occupies bits [i*W +: W].
REQ-010 SHALL have port req_ready, output, N_REQ, per-requester character accepted.
REQ-011 SHALL have port tx_wr, output, 1, TX buffer write strobe.
REQ-012 SHALL have port tx_d_in, output, UART_DATA_WIDTH, TX buffer write data.
REQ-013 SHALL have port tx_full, input, 1, TX buffer full.
REQ-014 SHALL have port grant_id, output, clog2(N_REQ), index of current or last owner.
REQ-015 SHALL have port busy, output, 1, high while state is STREAM.

Function
REQ-016 SHALL implement two states: IDLE and STREAM.
REQ-017 In IDLE with any req_valid high, SHALL pick the first valid requester at or after rr_ptr (modulo N_REQ), load grant_id, clear beat and idle counters, enter STREAM next cycle.
REQ-018 In IDLE with no req_valid, SHALL remain in IDLE; grant_id holds.
REQ-019 In IDLE, req_ready SHALL be all zero and tx_wr SHALL be 0; arbitration costs exactly one cycle.
REQ-020 In STREAM, transfer = req_valid[grant_id] && !tx_full; tx_wr and req_ready[grant_id] SHALL equal transfer combinationally; all other req_ready bits SHALL be 0.
REQ-021 tx_d_in SHALL equal req_data slice of grant_id whenever state is STREAM, regardless of transfer.
REQ-022 Each transfer SHALL increment beat counter (width clog2(MAX_BURST+1)).
REQ-023 Idle counter SHALL increment on cycles in STREAM with req_valid[grant_id] low, SHALL hold on tx_full stalls with valid high, SHALL clear on any transfer.
REQ-024 STREAM SHALL return to IDLE after a transfer with req_last[grant_id] high.
REQ-025 STREAM SHALL return to IDLE after the transfer that makes beat count equal MAX_BURST, even without req_last.
REQ-026 STREAM SHALL return to IDLE when idle counter reaches TIMEOUT-1 and req_valid[grant_id] is low (release after TIMEOUT idle cycles).
REQ-027 Simultaneous transfer and any release condition SHALL complete the transfer then release; transfer takes precedence over timeout.
REQ-028 On every STREAM->IDLE transition rr_ptr SHALL become (grant_id+1) mod N_REQ, wrapping N_REQ-1 to 0.
REQ-029 req_valid/req_data changes of non-granted requesters during STREAM SHALL have no effect.
REQ-030 tx_full held indefinitely with valid high SHALL never cause release nor loss of data.

Reset
REQ-031 reset low SHALL immediately force state IDLE, rr_ptr 0, grant_id 0, counters 0, busy 0, tx_wr 0, req_ready 0.
REQ-032 Reset asserted mid-STREAM SHALL abort the message without any further tx_wr; after release, arbitration restarts from requester 0.

Verification
REQ-033 Req 2 sends 3 chars, last on 3rd, tx_full 0 -> busy after 1 cycle, 3 consecutive tx_wr with matching data, IDLE, rr_ptr 3.
REQ-034 Req 0 and 3 valid continuously with rr_ptr 3 -> grant 3 first; after its last, grant 0; no interleaving of characters.
REQ-035 Req 1 streams 20 chars with no last, MAX_BURST 16 -> exactly 16 tx_wr, release, req 1 regranted if alone, remaining 4 chars sent.
REQ-036 Req 0 granted, drops valid 64 cycles -> release at 64th idle cycle; tx_full held 200 cycles with valid high -> no release, char written when tx_full falls.
REQ-037 reset pulsed low during 5th char of 10-char message -> tx_wr 0 immediately, busy 0, post-reset grant order starts at requester 0.
